// File: rtl/irq_aggr_pkg.sv
// Shared definitions for the interrupt aggregator: register map, CLAIM layout
// and the bus word type.
package irq_aggr_pkg;

  typedef logic [31:0] reg_word_t;

  localparam logic [4:0] IRQ_PEND_OFS  = 5'h00;
  localparam logic [4:0] IRQ_EN_OFS    = 5'h04;
  localparam logic [4:0] IRQ_MODE_OFS  = 5'h08;
  localparam logic [4:0] IRQ_POL_OFS   = 5'h0C;
  localparam logic [4:0] IRQ_CLAIM_OFS = 5'h10;
  localparam logic [4:0] IRQ_RAW_OFS   = 5'h14;

  localparam int CLAIM_ID_LSB    = 0;
  localparam int CLAIM_ID_W      = 5;
  localparam int CLAIM_VALID_BIT = 5;

  function automatic reg_word_t strb_to_mask(input logic [3:0] strb);
    reg_word_t m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{strb[b]}};
    return m;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder used to build the CLAIM word.
module irq_prio_enc
  import irq_aggr_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]            vec,
  output logic                    valid,
  output logic [CLAIM_ID_W-1:0]   id
);

  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        valid = 1'b1;
        id    = CLAIM_ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_aggr_ctrl.sv
// Interrupt aggregator: per-source sync, polarity, edge/level pending, enable,
// claim register and IRQ vector, exposed as a single native-memory-bus slave.
module irq_aggr_ctrl
  import irq_aggr_pkg::*;
#(
  parameter int NUM_SRC     = 32,
  parameter int SYNC_STAGES = 2,
  parameter int IRQ_BASE    = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               mem_valid_i,
  input  logic [4:0]         mem_addr_i,
  input  logic [31:0]        mem_wdata_i,
  input  logic [3:0]         mem_wstrb_i,
  output logic [31:0]        mem_rdata_o,
  output logic               mem_ready_o,
  output logic [31:0]        irq_o,
  output logic               irq_any_o
);

  logic [NUM_SRC-1:0] src_s, act, act_q, rise;
  logic [NUM_SRC-1:0] pend_q, en_q, mode_q, pol_q;
  logic [NUM_SRC-1:0] pend_nxt, en_nxt, mode_nxt, pol_nxt;
  logic [NUM_SRC-1:0] w1c, claim_clr, irq_vec, wdata_n, mask_n;
  reg_word_t          wmask, rd_word, irq_nxt;
  logic               wr_ack, rd_ack, c_valid;
  logic [CLAIM_ID_W-1:0] c_id;

  function automatic reg_word_t widen(input logic [NUM_SRC-1:0] v);
    reg_word_t w;
    w = '0;
    w[NUM_SRC-1:0] = v;
    return w;
  endfunction

  // Synchroniser stages
  for (genvar s = 0; s < SYNC_STAGES; s++) begin : g_stage
    logic [NUM_SRC-1:0] d, q;
    if (s == 0) begin : g_first
      assign d = src_i;
    end else begin : g_next
      assign d = g_stage[s-1].q;
    end
    always_ff @(posedge clk_i) begin
      if (rst_i) q <= '0;
      else       q <= d;
    end
  end

  if (SYNC_STAGES == 0) begin : g_bypass
    assign src_s = src_i;
  end else begin : g_synced
    assign src_s = g_stage[SYNC_STAGES-1].q;
  end

  assign act     = src_s ^ pol_q;
  assign wmask   = strb_to_mask(mem_wstrb_i);
  assign wdata_n = mem_wdata_i[NUM_SRC-1:0];
  assign mask_n  = wmask[NUM_SRC-1:0];

  irq_prio_enc #(.N(NUM_SRC)) u_prio (
    .vec   (pend_q & en_q),
    .valid (c_valid),
    .id    (c_id)
  );

  always_comb begin
    wr_ack   = mem_ready_o && mem_valid_i && (mem_wstrb_i != 4'h0);
    rd_ack   = mem_ready_o && mem_valid_i && (mem_wstrb_i == 4'h0);
    en_nxt   = en_q;
    mode_nxt = mode_q;
    pol_nxt  = pol_q;
    w1c      = '0;
    if (wr_ack) begin
      case (mem_addr_i)
        IRQ_PEND_OFS: w1c      = wdata_n & mask_n;
        IRQ_EN_OFS:   en_nxt   = (en_q & ~mask_n) | (wdata_n & mask_n);
        IRQ_MODE_OFS: mode_nxt = (mode_q & ~mask_n) | (wdata_n & mask_n);
        IRQ_POL_OFS:  pol_nxt  = (pol_q & ~mask_n) | (wdata_n & mask_n);
        default: ;
      endcase
    end
    // The claimed id is the one already returned in rdata, not a re-evaluation.
    claim_clr = '0;
    if (rd_ack && (mem_addr_i == IRQ_CLAIM_OFS) && mem_rdata_o[CLAIM_VALID_BIT]) begin
      for (int i = 0; i < NUM_SRC; i++)
        claim_clr[i] = (mem_rdata_o[CLAIM_ID_LSB +: CLAIM_ID_W] == CLAIM_ID_W'(i));
    end
    claim_clr = claim_clr & mode_q;
    rise      = act & ~act_q;
    // New edge is ORed after the clear so a coincident set wins.
    pend_nxt  = (mode_q & ((pend_q & ~(w1c | claim_clr)) | rise)) | (~mode_q & act);
    irq_vec   = pend_nxt & en_nxt;
    irq_nxt   = '0;
    irq_nxt[IRQ_BASE +: NUM_SRC] = irq_vec;
  end

  always_comb begin
    rd_word = '0;
    case (mem_addr_i)
      IRQ_PEND_OFS:  rd_word = widen(pend_q);
      IRQ_EN_OFS:    rd_word = widen(en_q);
      IRQ_MODE_OFS:  rd_word = widen(mode_q);
      IRQ_POL_OFS:   rd_word = widen(pol_q);
      IRQ_CLAIM_OFS: begin
        rd_word[CLAIM_VALID_BIT]                = c_valid;
        rd_word[CLAIM_ID_LSB +: CLAIM_ID_W]     = c_id;
      end
      IRQ_RAW_OFS:   rd_word = widen(act);
      default:       rd_word = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q      <= '0;
      en_q        <= '0;
      mode_q      <= '0;
      pol_q       <= '0;
      act_q       <= '0;
      irq_o       <= '0;
      irq_any_o   <= 1'b0;
      mem_ready_o <= 1'b0;
      mem_rdata_o <= '0;
    end else begin
      pend_q    <= pend_nxt;
      en_q      <= en_nxt;
      mode_q    <= mode_nxt;
      pol_q     <= pol_nxt;
      // History follows the next polarity so a POL write never looks like an edge.
      act_q     <= src_s ^ pol_nxt;
      irq_o     <= irq_nxt;
      irq_any_o <= |irq_vec;
      if (mem_ready_o) begin
        mem_ready_o <= 1'b0;
      end else if (mem_valid_i) begin
        mem_ready_o <= 1'b1;
        mem_rdata_o <= (mem_wstrb_i == 4'h0) ? rd_word : '0;
      end
    end
  end

endmodule

// File: tb/tb_irq_aggr_ctrl.sv
// Directed bench for irq_aggr_ctrl: bus reads are scoreboarded and checked by a
// separate monitor; IRQ outputs are checked at fixed cycle offsets.
module tb_irq_aggr_ctrl;
  import irq_aggr_pkg::*;

  localparam int NSRC = 24;
  localparam int SYNC = 2;
  localparam int BASE = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NSRC-1:0] src;
  logic            valid;
  logic [4:0]      addr;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic [31:0]     rdata;
  logic            ready;
  logic [31:0]     irq;
  logic            irq_any;

  int vec_cnt  = 0;
  int fail_cnt = 0;

  typedef struct {
    logic        chk;
    logic [4:0]  addr;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];
  sb_t mon_e;

  irq_aggr_ctrl #(.NUM_SRC(NSRC), .SYNC_STAGES(SYNC), .IRQ_BASE(BASE)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .src_i       (src),
    .mem_valid_i (valid),
    .mem_addr_i  (addr),
    .mem_wdata_i (wdata),
    .mem_wstrb_i (wstrb),
    .mem_rdata_o (rdata),
    .mem_ready_o (ready),
    .irq_o       (irq),
    .irq_any_o   (irq_any)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before 500us");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (ready) begin
      if (sb_q.size() == 0) begin
        vec_cnt++;
        fail_cnt++;
        $display("FAIL unexpected_ack: got ready=1 with no outstanding request");
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.chk) begin
          vec_cnt++;
          if (rdata !== mon_e.exp) begin
            fail_cnt++;
            $display("FAIL rd@0x%02h: got 0x%08h required 0x%08h", mon_e.addr, rdata, mon_e.exp);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
    end
  endtask

  task automatic wait_ack();
    int n = 0;
    while (n < 8) begin
      @(posedge clk);
      #1;
      if (ready) break;
      n++;
    end
    if (!ready) begin
      vec_cnt++;
      fail_cnt++;
      $display("FAIL ack_timeout@0x%02h: got no ready required ready within 8 cycles", addr);
      void'(sb_q.pop_back());
      valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      valid = 1'b0;
    end
  endtask

  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    sb_t e;
    e.chk = 1'b0; e.addr = a; e.exp = '0;
    sb_q.push_back(e);
    addr = a; wdata = d; wstrb = s; valid = 1'b1;
    wait_ack();
  endtask

  task automatic bus_rd(input logic [4:0] a, input logic [31:0] exp);
    sb_t e;
    e.chk = 1'b1; e.addr = a; e.exp = exp;
    sb_q.push_back(e);
    addr = a; wdata = '0; wstrb = 4'h0; valid = 1'b1;
    wait_ack();
  endtask

  task automatic do_reset();
    rst = 1'b1; src = '0; valid = 1'b0;
    tick(3);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; src = '0; valid = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    tick(2);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_irq", irq, 32'h0);
    check("rst_irq_any", 32'(irq_any), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    rst = 1'b0;

    // Level source 3
    bus_wr(IRQ_EN_OFS, 32'h8, 4'hF);
    src[3] = 1'b1;
    tick(2);
    check("lvl_irq_early", irq, 32'h0);
    tick(1);
    check("lvl_irq_set", irq, 32'h800);
    check("lvl_irq_any", 32'(irq_any), 32'h1);
    bus_wr(IRQ_PEND_OFS, 32'h8, 4'hF);
    bus_rd(IRQ_PEND_OFS, 32'h8);
    bus_rd(IRQ_RAW_OFS, 32'h8);
    bus_rd(IRQ_CLAIM_OFS, 32'h23);
    bus_rd(IRQ_PEND_OFS, 32'h8);
    src[3] = 1'b0;
    tick(2);
    check("lvl_irq_hold", irq, 32'h800);
    tick(1);
    check("lvl_irq_clr", irq, 32'h0);
    bus_rd(IRQ_PEND_OFS, 32'h0);

    // Active-low edge source 5, POL change must not create an edge
    do_reset();
    bus_wr(IRQ_MODE_OFS, 32'h20, 4'hF);
    bus_wr(IRQ_POL_OFS, 32'h20, 4'hF);
    bus_wr(IRQ_EN_OFS, 32'h20, 4'hF);
    tick(3);
    bus_rd(IRQ_PEND_OFS, 32'h0);
    bus_rd(IRQ_RAW_OFS, 32'h20);
    src[5] = 1'b1;
    tick(4);
    src[5] = 1'b0;
    tick(2);
    src[5] = 1'b1;
    tick(4);
    check("edge5_irq", irq, 32'h2000);
    bus_rd(IRQ_PEND_OFS, 32'h20);
    bus_rd(IRQ_CLAIM_OFS, 32'h25);
    bus_rd(IRQ_PEND_OFS, 32'h0);
    check("edge5_irq_clr", irq, 32'h0);

    // Two edge sources, lowest index claimed first
    do_reset();
    bus_wr(IRQ_MODE_OFS, 32'h84, 4'hF);
    bus_wr(IRQ_EN_OFS, 32'h84, 4'hF);
    src[2] = 1'b1;
    src[7] = 1'b1;
    tick(4);
    bus_rd(IRQ_CLAIM_OFS, 32'h22);
    bus_rd(IRQ_CLAIM_OFS, 32'h27);
    bus_rd(IRQ_CLAIM_OFS, 32'h00);
    bus_rd(IRQ_PEND_OFS, 32'h0);

    // Byte strobes, W1C, set-wins-over-clear, unmapped offsets
    do_reset();
    bus_wr(IRQ_MODE_OFS, 32'h1, 4'hF);
    bus_wr(IRQ_EN_OFS, 32'hFFFF_FFFF, 4'b1100);
    bus_rd(IRQ_EN_OFS, 32'h00FF_0000);
    src[0] = 1'b1;
    tick(1);
    src[0] = 1'b0;
    tick(4);
    bus_rd(IRQ_PEND_OFS, 32'h1);
    bus_wr(IRQ_PEND_OFS, 32'h1, 4'b0010);
    bus_rd(IRQ_PEND_OFS, 32'h1);
    bus_wr(IRQ_PEND_OFS, 32'h1, 4'hF);
    bus_rd(IRQ_PEND_OFS, 32'h0);
    src[0] = 1'b1;
    tick(1);
    bus_wr(IRQ_PEND_OFS, 32'h1, 4'hF);
    bus_rd(IRQ_PEND_OFS, 32'h1);
    src[0] = 1'b0;
    bus_wr(5'h18, 32'hFFFF_FFFF, 4'hF);
    bus_rd(5'h18, 32'h0);
    bus_rd(5'h1C, 32'h0);
    bus_rd(IRQ_MODE_OFS, 32'h1);

    // Masked source still latches; enabling exposes it next cycle
    do_reset();
    bus_wr(IRQ_MODE_OFS, 32'h2, 4'hF);
    src[1] = 1'b1;
    tick(1);
    src[1] = 1'b0;
    tick(4);
    check("mask_irq", irq, 32'h0);
    check("mask_irq_any", 32'(irq_any), 32'h0);
    bus_rd(IRQ_PEND_OFS, 32'h2);
    bus_wr(IRQ_EN_OFS, 32'h2, 4'hF);
    check("unmask_irq", irq, 32'h200);
    check("unmask_irq_any", 32'(irq_any), 32'h1);

    // Reset during an outstanding read
    bus_wr(IRQ_POL_OFS, 32'h10, 4'hF);
    addr = IRQ_PEND_OFS; wstrb = 4'h0; valid = 1'b1; rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check("rst_mid_ready", 32'(ready), 32'h0);
    end
    valid = 1'b0;
    rst = 1'b0;
    tick(1);
    check("rst_mid_irq", irq, 32'h0);
    bus_rd(IRQ_PEND_OFS, 32'h0);
    bus_rd(IRQ_EN_OFS, 32'h0);
    bus_rd(IRQ_MODE_OFS, 32'h0);
    bus_rd(IRQ_POL_OFS, 32'h0);
    bus_rd(IRQ_CLAIM_OFS, 32'h0);
    bus_rd(IRQ_RAW_OFS, 32'h0);

    tick(4);
    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
    $finish;
  end

endmodule
